// File: rtl/tube_tdc_pkg.sv
// Shared constants and FSM encoding for the tube TDC array.
package tube_tdc_pkg;

    localparam int unsigned DEF_NUM_TUBES = 4;
    localparam int unsigned DEF_CNT_W     = 8;
    localparam int unsigned DEF_WIN_MAX   = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } tdc_state_e;

    // Readout select width; a single-channel array still gets a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tube_tdc_array_if.sv
// Event readout bus: channel select, stamp/mask data and the valid/ack handshake.
interface tube_tdc_array_if
    import tube_tdc_pkg::*;
#(
    parameter int unsigned NUM_TUBES = DEF_NUM_TUBES,
    parameter int unsigned CNT_W     = DEF_CNT_W
);
    localparam int unsigned SEL_W = sel_width(NUM_TUBES);

    logic [SEL_W-1:0]     RD_SEL;
    logic [CNT_W-1:0]     RD_TIME;
    logic [NUM_TUBES-1:0] HIT_MASK;
    logic                 EVT_VALID;
    logic                 EVT_ACK;
    logic                 BUSY;

    // Readout host side.
    modport master (
        output RD_SEL,
        output EVT_ACK,
        input  RD_TIME,
        input  HIT_MASK,
        input  EVT_VALID,
        input  BUSY
    );

    // TDC side.
    modport slave (
        input  RD_SEL,
        input  EVT_ACK,
        output RD_TIME,
        output HIT_MASK,
        output EVT_VALID,
        output BUSY
    );

endinterface

// File: rtl/tube_tdc_channel.sv
// One tube channel: input edge sample, first-hit latch and stored time stamp.
module tube_tdc_channel
    import tube_tdc_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             armed,
    input  logic             tube_in,
    input  logic [CNT_W-1:0] count,
    output logic             hit,
    output logic [CNT_W-1:0] stamp
);

    logic             sample_q;
    logic             hit_q;
    logic [CNT_W-1:0] stamp_q;
    logic             rise;

    // A level already high on window entry has sample_q=1, so it cannot fire until it re-rises.
    assign rise = tube_in & ~sample_q;

    // Previous-cycle sample of the discriminator, running in every state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sample_q <= 1'b0;
        end else begin
            sample_q <= tube_in;
        end
    end

    // Latch the counter on the first rising edge of the window; later edges are ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_q   <= 1'b0;
            stamp_q <= '0;
        end else if (clear) begin
            hit_q   <= 1'b0;
            stamp_q <= '0;
        end else if (armed && rise && !hit_q) begin
            hit_q   <= 1'b1;
            stamp_q <= count;
        end
    end

    assign hit   = hit_q;
    assign stamp = stamp_q;

endmodule

// File: rtl/tube_tdc_array.sv
// Multi-channel tube TDC: a scintillator coincidence opens a capture window of
// WIN_MAX+1 cycles; each tube keeps the counter value of its first rising edge.
// Optional feature: define TUBE_TDC_HITCNT_EN to add the HIT_CNT popcount output.
module tube_tdc_array
    import tube_tdc_pkg::*;
#(
    parameter int unsigned NUM_TUBES = DEF_NUM_TUBES,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned WIN_MAX   = DEF_WIN_MAX
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SCIN_COINC,
    input  logic [NUM_TUBES-1:0] TUBE_IN,
    tube_tdc_array_if.slave      rd
`ifdef TUBE_TDC_HITCNT_EN
    ,
    output logic [$clog2(NUM_TUBES+1)-1:0] HIT_CNT
`endif
);

    localparam int unsigned SEL_W = sel_width(NUM_TUBES);

    tdc_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 clear;
    logic                 armed;
    logic [NUM_TUBES-1:0] hit;
    logic [CNT_W-1:0]     stamp [NUM_TUBES];
    logic [CNT_W-1:0]     rd_time;

    // State and window counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: arm on coincidence, count through the window, hold results until ack.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (SCIN_COINC) begin
                    clear   = 1'b1;
                    cnt_d   = '0;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // Last window cycle still captures; the counter stops instead of wrapping.
                if (cnt_q == CNT_W'(WIN_MAX)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Coincidences here are dropped, even alongside the ack.
                if (rd.EVT_ACK) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign armed = (state_q == ARMED);

    for (genvar i = 0; i < NUM_TUBES; i++) begin : g_chan
        tube_tdc_channel #(
            .CNT_W (CNT_W)
        ) u_chan (
            .CLK     (CLK),
            .RST     (RST),
            .clear   (clear),
            .armed   (armed),
            .tube_in (TUBE_IN[i]),
            .count   (cnt_q),
            .hit     (hit[i]),
            .stamp   (stamp[i])
        );
    end

    // Readout mux; unhit channels and out-of-range selects read as zero.
    always_comb begin
        rd_time = '0;
        for (int i = 0; i < NUM_TUBES; i++) begin
            if (rd.RD_SEL == SEL_W'(i) && hit[i]) begin
                rd_time = stamp[i];
            end
        end
    end

    assign rd.RD_TIME   = rd_time;
    assign rd.HIT_MASK  = hit;
    assign rd.EVT_VALID = (state_q == DONE);
    assign rd.BUSY      = (state_q != IDLE);

`ifdef TUBE_TDC_HITCNT_EN
    // Popcount of the hit mask; follows the mask, so it clears with it.
    always_comb begin
        HIT_CNT = '0;
        for (int i = 0; i < NUM_TUBES; i++) begin
            HIT_CNT = HIT_CNT + ($clog2(NUM_TUBES+1))'(hit[i]);
        end
    end
`endif

endmodule

// File: tb/tb_tube_tdc_array.sv
// Bench for tube_tdc_array: directed event scenarios plus randomised windows checked
// against an event-level reference model. Covers HIT_CNT when TUBE_TDC_HITCNT_EN is defined.
module tb_tube_tdc_array;
    import tube_tdc_pkg::*;

    localparam int unsigned NT = DEF_NUM_TUBES;
    localparam int unsigned CW = DEF_CNT_W;
    localparam int unsigned WM = DEF_WIN_MAX;
    localparam int unsigned SW = sel_width(NT);

    logic          CLK = 1'b0;
    logic          RST;
    logic          SCIN_COINC;
    logic [NT-1:0] TUBE_IN;
`ifdef TUBE_TDC_HITCNT_EN
    logic [$clog2(NT+1)-1:0] HIT_CNT;
`endif

    tube_tdc_array_if #(.NUM_TUBES(NT), .CNT_W(CW)) rd_if ();

    tube_tdc_array #(
        .NUM_TUBES (NT),
        .CNT_W     (CW),
        .WIN_MAX   (WM)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SCIN_COINC (SCIN_COINC),
        .TUBE_IN    (TUBE_IN),
        .rd         (rd_if)
`ifdef TUBE_TDC_HITCNT_EN
        ,
        .HIT_CNT    (HIT_CNT)
`endif
    );

    always #10 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Tube levels per window count, and the expected event result.
    logic [NT-1:0] wave [WM+1];
    logic [NT-1:0] exp_mask;
    logic [CW-1:0] exp_time [NT];

    task automatic clear_wave();
        for (int k = 0; k <= WM; k++) wave[k] = '0;
    endtask

    task automatic set_level(input int ch, input int from, input int to, input logic v);
        for (int k = from; k <= to; k++) wave[k][ch] = v;
    endtask

    // Reference: first 0->1 transition of each tube during window counts 0..WM.
    task automatic model_event(input logic [NT-1:0] pre);
        logic [NT-1:0] prev;
        prev     = pre;
        exp_mask = '0;
        for (int i = 0; i < NT; i++) exp_time[i] = '0;
        for (int k = 0; k <= WM; k++) begin
            for (int i = 0; i < NT; i++) begin
                if (wave[k][i] && !prev[i] && !exp_mask[i]) begin
                    exp_mask[i] = 1'b1;
                    exp_time[i] = CW'(k);
                end
            end
            prev = wave[k];
        end
    endtask

    // Starts at a negedge in IDLE, plays the wave through the window, checks DONE results.
    task automatic run_event(input logic [NT-1:0] pre, input bit noisy, input string tag);
        model_event(pre);
        SCIN_COINC    = 1'b1;
        TUBE_IN       = pre;
        rd_if.EVT_ACK = 1'b0;
        for (int k = 0; k <= WM; k++) begin
            @(negedge CLK);
            if (k == 0 || k == WM) begin
                checks++;
                if (rd_if.BUSY !== 1'b1 || rd_if.EVT_VALID !== 1'b0) begin
                    failures++;
                    $display("FAIL %s armed_status k=%0d busy=%b valid=%b required busy=1 valid=0",
                             tag, k, rd_if.BUSY, rd_if.EVT_VALID);
                end
            end
            SCIN_COINC    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            rd_if.EVT_ACK = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            TUBE_IN       = wave[k];
        end
        @(negedge CLK);
        SCIN_COINC    = 1'b0;
        rd_if.EVT_ACK = 1'b0;
        checks++;
        if (rd_if.EVT_VALID !== 1'b1 || rd_if.BUSY !== 1'b1) begin
            failures++;
            $display("FAIL %s done_status valid=%b busy=%b required 1 1",
                     tag, rd_if.EVT_VALID, rd_if.BUSY);
        end
        checks++;
        if (rd_if.HIT_MASK !== exp_mask) begin
            failures++;
            $display("FAIL %s hit_mask got=%b want=%b", tag, rd_if.HIT_MASK, exp_mask);
        end
        for (int i = 0; i < NT; i++) begin
            rd_if.RD_SEL = SW'(i);
            #1;
            checks++;
            if (rd_if.RD_TIME !== exp_time[i]) begin
                failures++;
                $display("FAIL %s rd_time[%0d] got=%0d want=%0d", tag, i, rd_if.RD_TIME,
                         exp_time[i]);
            end
        end
`ifdef TUBE_TDC_HITCNT_EN
        checks++;
        if (HIT_CNT !== ($clog2(NT+1))'($countones(exp_mask))) begin
            failures++;
            $display("FAIL %s hit_cnt got=%0d want=%0d", tag, HIT_CNT, $countones(exp_mask));
        end
`endif
        // Results must hold in DONE whatever the tubes and coincidence do.
        for (int n = 0; n < 3; n++) begin
            TUBE_IN    = NT'($urandom);
            SCIN_COINC = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge CLK);
            checks++;
            if (rd_if.HIT_MASK !== exp_mask || rd_if.EVT_VALID !== 1'b1) begin
                failures++;
                $display("FAIL %s done_hold n=%0d mask=%b valid=%b want mask=%b valid=1",
                         tag, n, rd_if.HIT_MASK, rd_if.EVT_VALID, exp_mask);
            end
        end
        SCIN_COINC = 1'b0;
    endtask

    // Acknowledge from DONE, optionally with a simultaneous coincidence that must be ignored.
    task automatic do_ack(input logic coinc, input string tag);
        rd_if.EVT_ACK = 1'b1;
        SCIN_COINC    = coinc;
        @(negedge CLK);
        rd_if.EVT_ACK = 1'b0;
        SCIN_COINC    = 1'b0;
        checks++;
        if (rd_if.BUSY !== 1'b0 || rd_if.EVT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL %s ack_release busy=%b valid=%b required 0 0",
                     tag, rd_if.BUSY, rd_if.EVT_VALID);
        end
        @(negedge CLK);
        checks++;
        if (rd_if.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL %s no_rearm busy=%b required 0", tag, rd_if.BUSY);
        end
    endtask

    task automatic test_reset();
        RST           = 1'b1;
        SCIN_COINC    = 1'b0;
        TUBE_IN       = '0;
        rd_if.RD_SEL  = '0;
        rd_if.EVT_ACK = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (rd_if.BUSY !== 1'b0 || rd_if.EVT_VALID !== 1'b0 || rd_if.HIT_MASK !== '0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b valid=%b mask=%b required 0 0 0",
                     rd_if.BUSY, rd_if.EVT_VALID, rd_if.HIT_MASK);
        end
        for (int i = 0; i < NT; i++) begin
            rd_if.RD_SEL = SW'(i);
            #1;
            checks++;
            if (rd_if.RD_TIME !== '0) begin
                failures++;
                $display("FAIL reset_rd_time[%0d] got=%0d want=0", i, rd_if.RD_TIME);
            end
        end
        RST = 1'b0;
    endtask

    task automatic test_single_hit();
        clear_wave();
        set_level(2, 5, WM, 1'b1);
        run_event('0, 1'b0, "single_hit");
        checks++;
        if (rd_if.HIT_MASK !== NT'(4)) begin
            failures++;
            $display("FAIL single_hit_mask got=%b want=0100", rd_if.HIT_MASK);
        end
        rd_if.RD_SEL = SW'(2);
        #1;
        checks++;
        if (rd_if.RD_TIME !== CW'(5)) begin
            failures++;
            $display("FAIL single_hit_sel2 got=%0d want=5", rd_if.RD_TIME);
        end
        rd_if.RD_SEL = SW'(0);
        #1;
        checks++;
        if (rd_if.RD_TIME !== CW'(0)) begin
            failures++;
            $display("FAIL single_hit_sel0 got=%0d want=0", rd_if.RD_TIME);
        end
        do_ack(1'b0, "single_hit");
    endtask

    task automatic test_first_hit_kept();
        clear_wave();
        set_level(1, 3, 5, 1'b1);
        set_level(1, 9, WM, 1'b1);
        run_event('0, 1'b0, "first_hit");
        rd_if.RD_SEL = SW'(1);
        #1;
        checks++;
        if (rd_if.RD_TIME !== CW'(3)) begin
            failures++;
            $display("FAIL first_hit_kept got=%0d want=3", rd_if.RD_TIME);
        end
        do_ack(1'b0, "first_hit");
    endtask

    task automatic test_pre_high();
        clear_wave();
        set_level(3, 0, 9, 1'b1);
        set_level(3, 15, WM, 1'b1);
        run_event(NT'(8), 1'b0, "pre_high");
        rd_if.RD_SEL = SW'(3);
        #1;
        checks++;
        if (rd_if.RD_TIME !== CW'(15)) begin
            failures++;
            $display("FAIL pre_high_rerise got=%0d want=15", rd_if.RD_TIME);
        end
        do_ack(1'b0, "pre_high");
    endtask

    task automatic test_win_max();
        clear_wave();
        set_level(0, WM, WM, 1'b1);
        run_event('0, 1'b0, "win_max");
        rd_if.RD_SEL = SW'(0);
        #1;
        checks++;
        if (rd_if.RD_TIME !== CW'(WM) || rd_if.HIT_MASK !== NT'(1)) begin
            failures++;
            $display("FAIL win_max_capture time=%0d mask=%b want time=%0d mask=0001",
                     rd_if.RD_TIME, rd_if.HIT_MASK, WM);
        end
        do_ack(1'b0, "win_max");
    endtask

    task automatic test_ack_coinc();
        clear_wave();
        set_level(1, 7, 20, 1'b1);
        run_event('0, 1'b0, "ack_coinc");
        do_ack(1'b1, "ack_coinc");
        clear_wave();
        set_level(0, 2, WM, 1'b1);
        run_event('0, 1'b0, "rearm_after_ack");
        do_ack(1'b0, "rearm_after_ack");
    endtask

    task automatic test_reset_mid();
        clear_wave();
        set_level(0, 10, WM, 1'b1);
        set_level(1, 20, WM, 1'b1);
        SCIN_COINC = 1'b1;
        TUBE_IN    = '0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge CLK);
            SCIN_COINC = 1'b0;
            TUBE_IN    = wave[k];
        end
        checks++;
        if (rd_if.HIT_MASK !== NT'(3)) begin
            failures++;
            $display("FAIL reset_mid_prehits got=%b want=0011", rd_if.HIT_MASK);
        end
        #4;
        RST = 1'b1;
        #1;
        checks++;
        if (rd_if.BUSY !== 1'b0 || rd_if.EVT_VALID !== 1'b0 || rd_if.HIT_MASK !== '0) begin
            failures++;
            $display("FAIL reset_mid_async busy=%b valid=%b mask=%b required 0 0 0",
                     rd_if.BUSY, rd_if.EVT_VALID, rd_if.HIT_MASK);
        end
        for (int i = 0; i < 2; i++) begin
            rd_if.RD_SEL = SW'(i);
            #1;
            checks++;
            if (rd_if.RD_TIME !== '0) begin
                failures++;
                $display("FAIL reset_mid_rd_time[%0d] got=%0d want=0", i, rd_if.RD_TIME);
            end
        end
        @(negedge CLK);
        RST     = 1'b0;
        TUBE_IN = '0;
        // Next event arms on the very first clock after release.
        clear_wave();
        set_level(2, 1, WM, 1'b1);
        run_event('0, 1'b0, "after_reset");
        do_ack(1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [NT-1:0] pre;
        logic          lvl;
        for (int e = 0; e < 6; e++) begin
            pre = NT'($urandom);
            for (int i = 0; i < NT; i++) begin
                lvl = pre[i];
                for (int k = 0; k <= WM; k++) begin
                    if ($urandom_range(0, 59) == 0) lvl = ~lvl;
                    wave[k][i] = lvl;
                end
            end
            run_event(pre, 1'b1, $sformatf("random%0d", e));
            do_ack(1'($urandom_range(0, 1)), $sformatf("random%0d", e));
        end
    endtask

`ifdef TUBE_TDC_HITCNT_EN
    task automatic test_hitcnt();
        clear_wave();
        set_level(0, 4, WM, 1'b1);
        set_level(1, 30, WM, 1'b1);
        set_level(3, 100, WM, 1'b1);
        run_event('0, 1'b0, "hitcnt");
        checks++;
        if (HIT_CNT !== 3) begin
            failures++;
            $display("FAIL hitcnt_three got=%0d want=3", HIT_CNT);
        end
        do_ack(1'b0, "hitcnt");
    endtask
`endif

    initial begin
        test_reset();
        test_single_hit();
        test_first_hit_kept();
        test_pre_high();
        test_win_max();
        test_ack_coinc();
        test_reset_mid();
        test_random();
`ifdef TUBE_TDC_HITCNT_EN
        test_hitcnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL timeout simulation exceeded 1 ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tube_tdc_array.md
TUBE_TDC_ARRAY -- requirements
Module: tube_tdc_array

Interface
REQ-001 SHALL have parameter NUM_TUBES, default 4, number of tube channels (1..64).
REQ-002 SHALL have parameter CNT_W, default 8, width of the window counter and stored time stamps.
REQ-003 SHALL have parameter WIN_MAX, default 255, last counter value of the capture window (must be less than 2**CNT_W).
REQ-004 SHALL have port CLK  input  1  system clock, 20 ns period, all logic on the rising edge.
REQ-005 SHALL have port RST  input  1  reset: one clock, asynchronous, active-high.
REQ-006 SHALL have port SCIN_COINC  input  1  scintillator coincidence that starts an event window.
REQ-007 SHALL have port TUBE_IN  input  NUM_TUBES  tube discriminator levels.
REQ-008 SHALL have port RD_SEL  input  clog2(NUM_TUBES), minimum 1  readout channel select.
REQ-009 SHALL have port RD_TIME  output  CNT_W  stored time stamp of channel RD_SEL.
REQ-010 SHALL have port HIT_MASK  output  NUM_TUBES  per-channel "hit captured this event" flags.
REQ-011 SHALL have port EVT_VALID  output  1  event complete and data stable.
REQ-012 SHALL have port EVT_ACK  input  1  readout done, release the event.
REQ-013 SHALL have port BUSY  output  1  high in ARMED or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, ARMED and DONE.
REQ-015 SHALL, in IDLE with SCIN_COINC=1, clear counter, all time stamps and HIT_MASK, and enter ARMED next cycle.
REQ-016 SHALL, in ARMED, increment the counter by 1 per cycle, starting from 0 in the first ARMED cycle.
REQ-017 SHALL detect a rising edge on channel i when TUBE_IN[i]=1 and the previous-cycle sample was 0; the sample register updates every cycle in all states.
REQ-018 SHALL, on the first rising edge of channel i in ARMED, store the current counter value and set HIT_MASK[i]; later edges in the same event are ignored.
REQ-019 SHALL not record a hit for a channel already high when ARMED is entered, until it falls and rises again.
REQ-020 SHALL, when counter equals WIN_MAX in ARMED, still capture edges in that cycle, then enter DONE; the counter never wraps.
REQ-021 SHALL drive EVT_VALID=1 in DONE only; RD_TIME and HIT_MASK hold constant in DONE.
REQ-022 SHALL return from DONE to IDLE on the cycle EVT_ACK=1; EVT_ACK outside DONE has no effect.
REQ-023 SHALL ignore SCIN_COINC in ARMED and DONE, including a coincidence in the same cycle as EVT_ACK; no re-arm occurs until IDLE.
REQ-024 SHALL read RD_TIME combinationally from the selected stored stamp; RD_SEL >= NUM_TUBES yields 0.
REQ-025 SHALL report RD_TIME=0 for channels with HIT_MASK bit clear.

Reset
REQ-026 SHALL, on RST=1 at any time including mid-window, force IDLE, counter 0, all stamps 0, HIT_MASK 0, EVT_VALID 0, BUSY 0, and edge-sample registers 0.
REQ-027 SHALL start accepting SCIN_COINC on the first rising CLK after RST deasserts.

Configuration
REQ-028 SHALL compile a hit counter only when macro TUBE_TDC_HITCNT_EN is defined.
REQ-029 SHALL, with TUBE_TDC_HITCNT_EN defined, add output HIT_CNT (clog2(NUM_TUBES+1) bits) equal to popcount of HIT_MASK, updated with the mask and reset to 0.
REQ-030 SHALL, with TUBE_TDC_HITCNT_EN undefined, have no HIT_CNT port and no related logic; all other behaviour is identical.

Structure
REQ-031 SHALL place the FSM state encoding (IDLE=0, ARMED=1, DONE=2, 2 bits) and default NUM_TUBES/CNT_W/WIN_MAX constants in shared package tube_tdc_pkg.
REQ-032 SHALL instantiate one sub-module tube_tdc_channel per tube, containing the edge sample, first-hit latch and stored stamp; the top holds the FSM, counter and readout mux.

Verification
REQ-033 SHALL cover: RST, SCIN_COINC pulse, TUBE_IN[2] rises 5 cycles after ARMED entry -> in DONE, HIT_MASK=0100, RD_SEL=2 gives RD_TIME=5, RD_SEL=0 gives 0.
REQ-034 SHALL cover: tube 1 rises at counts 3 and 9 -> RD_TIME=3 (first hit kept).
REQ-035 SHALL cover: tube 0 rises at count 255 (WIN_MAX) -> captured as 255; EVT_VALID rises the next cycle; the counter does not wrap.
REQ-036 SHALL cover: SCIN_COINC and EVT_ACK both high in DONE -> IDLE, no new window; a later SCIN_COINC arms normally.
REQ-037 SHALL cover: RST asserted at count 40 with 2 hits -> all outputs 0 asynchronously, state IDLE.
REQ-038 SHALL cover: with TUBE_TDC_HITCNT_EN, tubes 0, 1 and 3 hit -> HIT_CNT=3; the build without the macro elaborates without HIT_CNT.
